uart_rx: RTL and testbench

Serial receiver stage feeding the interface circuit that assembles ALU operands and opcode. It oversamples the asynchronous `UART_TXD_IN` line at `NUM_TICKS`× the baud rate using an internal baud-tick generator. It reconstructs 8N1 frames, LSB first, and presents each good byte with a one-cycle strobe (`data_out` / `rx_done_tick`), the same contract the interface circuit already consumes. Frames with a bad stop bit are flagged and discarded.

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_baud_rate_gen.sv | 34 +++
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: data width, receiver FSM encodings and the baud divider computation.
package uart_rx_pkg;

  localparam int unsigned LEN_DATA = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StStart = 2'b01,
    StData  = 2'b10,
    StStop  = 2'b11
  } rx_state_e;

  // Clocks per oversampling tick, floored; shared with the transmitter.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate,
                                           input int unsigned num_ticks);
    return clk_freq / (baud_rate * num_ticks);
  endfunction

endpackage

// File: rtl/uart_rx_baud_rate_gen.sv
// Free-running oversampling tick generator; never re-phased by frame activity.
module baud_rate_gen
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned NUM_TICKS = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned Div  = calc_div(CLK_FREQ, BAUD_RATE, NUM_TICKS);
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: input synchronizer, oversampled start/data/stop FSM, registered strobes.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned NBITS     = LEN_DATA,
  parameter int unsigned NUM_TICKS = 16,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned CLK_FREQ  = 100_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic [NBITS-1:0] data_out,
  output logic             rx_done_tick,
  output logic             framing_error
);

  localparam int unsigned SW = $clog2(NUM_TICKS);
  localparam int unsigned NW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [SW-1:0] SHalf = SW'(NUM_TICKS / 2 - 1);
  localparam logic [SW-1:0] SLast = SW'(NUM_TICKS - 1);
  localparam logic [NW-1:0] NLast = NW'(NBITS - 1);

  logic             tick;
  logic             rx_meta_q, rx_s, rx_prev_q;
  rx_state_e        state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [NW-1:0]    n_q, n_d;
  logic [NBITS-1:0] b_q, b_d;
  logic [NBITS-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;

  baud_rate_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .NUM_TICKS(NUM_TICKS)
  ) u_baud_rate_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Synchronizer and edge-detect history idle high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
      rx_prev_q <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    unique case (state_q)
      StIdle: begin
        if (rx_prev_q && !rx_s) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (s_q == SHalf) begin
            if (!rx_s) begin
              state_d = StData;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      StData: begin
        if (tick) begin
          if (s_q == SLast) begin
            b_d = {rx_s, b_q[NBITS-1:1]};
            s_d = '0;
            if (n_q == NLast) begin
              state_d = StStop;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (s_q == SLast) begin
            state_d = StIdle;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Stop-bit sample decides between delivering the byte and flagging a framing error.
  always_comb begin
    data_d = data_q;
    done_d = 1'b0;
    ferr_d = 1'b0;
    if (state_q == StStop && tick && s_q == SLast) begin
      if (rx_s) begin
        data_d = b_q;
        done_d = 1'b1;
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  assign data_out      = data_q;
  assign rx_done_tick  = done_q;
  assign framing_error = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with DIV=4 (64 clk per bit) and hand-computed expectations.
module tb_uart_rx;

  localparam int unsigned ClkFreq = 614_400;  // 9600 * 16 * 4
  localparam int BitClk = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_done_tick;
  logic       framing_error;

  uart_rx #(
    .NBITS    (8),
    .NUM_TICKS(16),
    .BAUD_RATE(9600),
    .CLK_FREQ (ClkFreq)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .data_out     (data_out),
    .rx_done_tick (rx_done_tick),
    .framing_error(framing_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int prev_done_cyc = 0;
  int last_done_cyc = 0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] last_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor samples on the falling edge, away from the register updates.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      prev_data     = last_data;
      last_data     = data_out;
    end
    if (framing_error) ferr_cnt++;
    if (rx_done_tick && framing_error) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the line at the stop-bit level; caller decides what follows.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int bclk);
    rx = 1'b0;
    wait_clks(bclk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(bclk);
    end
    rx = stop_v;
    wait_clks(bclk);
  endtask

  int d0, f0;

  initial begin
    rx    = 1'b1;
    reset = 1'b1;
    wait_clks(4);
    reset = 1'b0;
    wait_clks(2);
    check("reset_data", 32'(data_out), 32'h00);
    check("reset_done", 32'(rx_done_tick), 32'h0);
    check("reset_ferr", 32'(framing_error), 32'h0);
    wait_clks(20);

    // Clean 0x55
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b1, BitClk);
    wait_clks(100);
    check("t55_done_cnt", done_cnt - d0, 1);
    check("t55_ferr_cnt", ferr_cnt - f0, 0);
    check("t55_data", 32'(data_out), 32'h55);
    check("t55_strobe_data", 32'(last_data), 32'h55);

    // Back-to-back 0xA3, 0x0F
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'hA3, 1'b1, BitClk);
    send_frame(8'h0F, 1'b1, BitClk);
    wait_clks(100);
    check("b2b_done_cnt", done_cnt - d0, 2);
    check("b2b_ferr_cnt", ferr_cnt - f0, 0);
    check("b2b_spacing", last_done_cyc - prev_done_cyc, 640);
    check("b2b_first", 32'(prev_data), 32'hA3);
    check("b2b_second", 32'(last_data), 32'h0F);
    check("b2b_data", 32'(data_out), 32'h0F);

    // 12-clk low glitch on idle line
    d0 = done_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    wait_clks(12);
    rx = 1'b1;
    wait_clks(200);
    check("glitch_done_cnt", done_cnt - d0, 0);
    check("glitch_ferr_cnt", ferr_cnt - f0, 0);
    check("glitch_data", 32'(data_out), 32'h0F);

    // 0x3C with a low stop bit, line held low two more bit-times
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, BitClk);
    wait_clks(2 * BitClk);
    rx = 1'b1;
    wait_clks(200);
    check("ferr_ferr_cnt", ferr_cnt - f0, 1);
    check("ferr_done_cnt", done_cnt - d0, 0);
    check("ferr_data", 32'(data_out), 32'h0F);

    // Reset in the middle of data bit 4 of 0x81
    d0 = done_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    wait_clks(BitClk);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0) ? 1'b1 : 1'b0;
      wait_clks(BitClk);
    end
    rx = 1'b0;
    wait_clks(BitClk / 2);
    reset = 1'b1;
    rx    = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    check("rst_data_now", 32'(data_out), 32'h00);
    check("rst_done_now", 32'(rx_done_tick), 32'h0);
    check("rst_ferr_now", 32'(framing_error), 32'h0);
    wait_clks(700);
    check("rst_done_cnt", done_cnt - d0, 0);
    check("rst_ferr_cnt", ferr_cnt - f0, 0);
    check("rst_data_after", 32'(data_out), 32'h00);
    d0 = done_cnt;
    send_frame(8'h7E, 1'b1, BitClk);
    rx = 1'b1;
    wait_clks(100);
    check("t7e_done_cnt", done_cnt - d0, 1);
    check("t7e_data", 32'(data_out), 32'h7E);

    // 0xC6 at ~3 % fast (62 clk/bit) and ~3 % slow (66 clk/bit)
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'hC6, 1'b1, 62);
    rx = 1'b1;
    wait_clks(150);
    check("fast_done_cnt", done_cnt - d0, 1);
    check("fast_ferr_cnt", ferr_cnt - f0, 0);
    check("fast_data", 32'(last_data), 32'hC6);
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'hC6, 1'b1, 66);
    rx = 1'b1;
    wait_clks(150);
    check("slow_done_cnt", done_cnt - d0, 1);
    check("slow_ferr_cnt", ferr_cnt - f0, 0);
    check("slow_data", 32'(data_out), 32'hC6);

    check("strobes_exclusive", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
